// File: rtl/qif_pkg.sv
// Shared constants, sweep state type and saturation helper for the QIF neuron array.
package qif_pkg;

   localparam int W_DEF       = 8;
   localparam int V_TH_DEF    = 50;
   localparam int V_RESET_DEF = -20;
   localparam int I_SHIFT_DEF = 2;
   localparam int Q_SHIFT_DEF = 3;

   typedef enum logic {
      IDLE,
      SWEEP
   } sweep_state_e;

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                              input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage

// File: rtl/qif_spike_fifo.sv
// Synchronous spike-event FIFO; a push while full succeeds when a pop happens on the same edge.
module qif_spike_fifo
   import qif_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      full    = (count == (AW+1)'(DEPTH));
      empty   = (count == '0);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      dout    = mem[rd_ptr];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire membrane array with refractory hold,
// buffered spike events and combinational membrane readout.
module qif_neuron_array
   import qif_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int W          = W_DEF,
   parameter int V_TH       = V_TH_DEF,
   parameter int V_RESET    = V_RESET_DEF,
   parameter int I_SHIFT    = I_SHIFT_DEF,
   parameter int Q_SHIFT    = Q_SHIFT_DEF,
   parameter int REFRAC     = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step,
   input  logic [N_CH*W-1:0] i_syn,
   output logic              busy,
   output logic              done,
   output logic              spk_valid,
   input  logic              spk_ready,
   output logic [CW-1:0]     spk_ch,
   output logic              ovf,
   input  logic              clr_ovf,
   input  logic [CW-1:0]     rd_ch,
   output logic [W-1:0]      rd_vmem
);

   localparam int SW = 2*W + 2;
   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic signed [W-1:0] VTH_W    = W'(V_TH);
   localparam logic signed [W-1:0] VRESET_W = W'(V_RESET);
   localparam logic [RW-1:0]       REFRAC_R = RW'(REFRAC);
   localparam logic [CW-1:0]       LAST     = CW'(N_CH - 1);

   sweep_state_e state, state_nx;

   logic signed [W-1:0]  v    [N_CH];
   logic [RW-1:0]        refr [N_CH];
   logic [N_CH*W-1:0]    i_cap;
   logic [CW-1:0]        idx;

   logic signed [W-1:0]  cur_v, cur_i, i_sh, q_sh, v_new;
   logic signed [SW-1:0] v_ext, i_ext, q_ext, q_term, sum;
   logic                 refr_active;
   logic                 fire;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (step) state_nx = SWEEP;
         SWEEP:   if (idx == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SWEEP);
   end

   // Shared update datapath; the sum is formed wide enough that it can never wrap before clamping.
   always_comb begin
      cur_v       = v[idx];
      cur_i       = i_cap[int'(idx)*W +: W];
      i_sh        = cur_i >>> I_SHIFT;
      q_sh        = cur_v >>> Q_SHIFT;
      v_ext       = {{(SW-W){cur_v[W-1]}}, cur_v};
      i_ext       = {{(SW-W){i_sh[W-1]}}, i_sh};
      q_ext       = {{(SW-W){q_sh[W-1]}}, q_sh};
      q_term      = q_ext * q_ext;
      sum         = v_ext + i_ext + q_term;
      v_new       = W'(sat({{(64-SW){sum[SW-1]}}, sum}, W));
      refr_active = (refr[idx] != '0);
      fire        = (state == SWEEP) && !refr_active && (cur_v >= VTH_W);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int unsigned k = 0; k < N_CH; k++) begin
            v[k]    <= '0;
            refr[k] <= '0;
         end
         i_cap <= '0;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && step) begin
            i_cap <= i_syn;
            idx   <= '0;
         end
         if (state == SWEEP) begin
            if (refr_active) begin
               v[idx]    <= VRESET_W;
               refr[idx] <= refr[idx] - RW'(1);
            end else if (cur_v >= VTH_W) begin
               v[idx]    <= VRESET_W;
               refr[idx] <= REFRAC_R;
            end else begin
               v[idx]    <= v_new;
            end
            idx  <= (idx == LAST) ? '0 : idx + CW'(1);
            done <= (idx == LAST);
         end
      end
   end

   always_comb begin
      spk_valid = ~fifo_empty;
      pop       = spk_valid & spk_ready;
   end

   qif_spike_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fire),
      .din   (idx),
      .pop   (pop),
      .dout  (spk_ch),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A dropped event wins over a same-cycle clear so the loss is never hidden.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)                          ovf <= 1'b0;
      else if (fire && fifo_full && !pop) ovf <= 1'b1;
      else if (clr_ovf)                   ovf <= 1'b0;
   end

   always_comb begin
      rd_vmem = '0;
      if (int'(rd_ch) < N_CH) rd_vmem = v[rd_ch];
   end

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed checks of the QIF neuron array: integration, refractory hold, saturation,
// spike FIFO ordering/overflow, step handling and mid-sweep reset.
module tb_qif_neuron_array;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic        step, busy, done, spk_valid, spk_ready, ovf, clr_ovf;
   logic [31:0] i_syn;
   logic [1:0]  spk_ch, rd_ch;
   logic signed [7:0] rd_vmem;

   logic        step_b, busy_b, done_b, spk_valid_b, spk_ready_b, ovf_b, clr_ovf_b;
   logic [31:0] i_syn_b;
   logic [1:0]  spk_ch_b, rd_ch_b;
   logic signed [7:0] rd_vmem_b;

   int total = 0;
   int bad   = 0;
   int busy_n, done_n;

   always #5 clk = ~clk;

   qif_neuron_array #(
      .N_CH (N_CH),
      .W    (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (step),
      .i_syn     (i_syn),
      .busy      (busy),
      .done      (done),
      .spk_valid (spk_valid),
      .spk_ready (spk_ready),
      .spk_ch    (spk_ch),
      .ovf       (ovf),
      .clr_ovf   (clr_ovf),
      .rd_ch     (rd_ch),
      .rd_vmem   (rd_vmem)
   );

   qif_neuron_array #(
      .N_CH (N_CH),
      .W    (W),
      .V_TH (127)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (step_b),
      .i_syn     (i_syn_b),
      .busy      (busy_b),
      .done      (done_b),
      .spk_valid (spk_valid_b),
      .spk_ready (spk_ready_b),
      .spk_ch    (spk_ch_b),
      .ovf       (ovf_b),
      .clr_ovf   (clr_ovf_b),
      .rd_ch     (rd_ch_b),
      .rd_vmem   (rd_vmem_b)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input int c, input int exp, input string tag);
      rd_ch = 2'(c);
      #1;
      chk(tag, rd_vmem, exp);
   endtask

   task automatic chk_vb(input int exp, input string tag);
      rd_ch_b = 2'd0;
      #1;
      chk(tag, rd_vmem_b, exp);
   endtask

   task automatic do_step(input logic [31:0] vec);
      i_syn = vec;
      step  = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (N_CH) @(negedge clk);
   endtask

   task automatic do_step_b(input logic [31:0] vec);
      i_syn_b = vec;
      step_b  = 1'b1;
      @(negedge clk);
      step_b = 1'b0;
      repeat (N_CH) @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      step = 1'b0; i_syn = '0; spk_ready = 1'b0; clr_ovf = 1'b0; rd_ch = '0;
      step_b = 1'b0; i_syn_b = '0; spk_ready_b = 1'b0; clr_ovf_b = 1'b0; rd_ch_b = '0;

      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_spk_valid", spk_valid, 0);
      chk("rst_spk_ch", spk_ch, 0);
      chk("rst_ovf", ovf, 0);
      for (int c = 0; c < N_CH; c++) chk_v(c, 0, "rst_vmem");

      // Ch0 integrates toward threshold, then spikes and is held refractory.
      do_step(32'h0000_0028);
      chk("a_done", done, 1);
      chk("a_busy", busy, 0);
      chk_v(0, 10, "a_v0_s1");
      do_step(32'h0000_0028);
      chk_v(0, 21, "a_v0_s2");
      do_step(32'h0000_0028);
      chk_v(0, 35, "a_v0_s3");
      do_step(32'h0000_0028);
      chk_v(0, 61, "a_v0_s4");
      chk("a_no_spike_yet", spk_valid, 0);
      do_step(32'h0000_0028);
      chk_v(0, -20, "a_v0_spike");
      chk("a_spk_valid", spk_valid, 1);
      chk("a_spk_ch", spk_ch, 0);
      chk_v(1, 0, "a_v1_idle");
      chk_v(3, 0, "a_v3_idle");
      spk_ready = 1'b1;
      @(negedge clk);
      spk_ready = 1'b0;
      chk("a_popped", spk_valid, 0);
      do_step(32'h0000_0028);
      chk_v(0, -20, "b_refr1");
      do_step(32'h0000_0028);
      chk_v(0, -20, "b_refr2");
      do_step(32'h0000_0028);
      chk_v(0, -1, "b_integrate");

      // All channels spike in one sweep into a stalled FIFO, then overflow later.
      reset_pulse();
      do_step(32'h7F7F_7F7F);
      chk_v(2, 31, "f_v2_s1");
      do_step(32'h7F7F_7F7F);
      chk_v(3, 71, "f_v3_s2");
      do_step(32'h7F7F_7F7F);
      chk("f_valid", spk_valid, 1);
      chk("f_head", spk_ch, 0);
      chk("f_ovf_full", ovf, 0);
      chk_v(1, -20, "f_v1_reset");
      do_step(32'h7F7F_7F7F);
      do_step(32'h7F7F_7F7F);
      chk("f_ovf_refr", ovf, 0);
      do_step(32'h7F7F_7F7F);
      chk_v(0, 20, "f_v0_s6");
      do_step(32'h7F7F_7F7F);
      chk_v(0, 55, "f_v0_s7");
      chk("f_ovf_pre", ovf, 0);
      do_step(32'h7F7F_7F7F);
      chk("f_ovf_set", ovf, 1);
      spk_ready = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
         chk("f_pop_valid", spk_valid, 1);
         chk("f_pop_ch", spk_ch, k);
         @(negedge clk);
      end
      spk_ready = 1'b0;
      chk("f_drained", spk_valid, 0);
      chk("f_ovf_sticky", ovf, 1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("f_ovf_clr", ovf, 0);

      // Step held high: one sweep only, later i_syn changes must not be captured.
      reset_pulse();
      busy_n = 0;
      done_n = 0;
      i_syn  = 32'h0000_0028;
      step   = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 2) i_syn = 32'h0000_0080;
         if (n == 5) step = 1'b0;
         busy_n += int'(busy);
         done_n += int'(done);
      end
      chk("h_busy_cycles", busy_n, 4);
      chk("h_done_pulses", done_n, 1);
      chk_v(0, 10, "h_v0_once");

      // Reset while idx=2: nothing from the aborted sweep survives.
      i_syn = 32'h7F7F_7F7F;
      step  = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      chk("m_busy_mid", busy, 1);
      chk_v(0, 42, "m_v0_mid");
      rst_n = 1'b1;
      #1;
      chk("m_busy_async", busy, 0);
      @(negedge clk);
      rst_n  = 1'b0;
      done_n = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         done_n += int'(done);
      end
      chk("m_no_done", done_n, 0);
      chk("m_fifo_empty", spk_valid, 0);
      for (int c = 0; c < N_CH; c++) chk_v(c, 0, "m_vmem_clear");
      do_step(32'h0000_0028);
      chk("m_done_after", done, 1);
      chk_v(0, 10, "m_v0_after");

      // Saturation with a raised threshold: the large positive sum clamps, it never wraps.
      reset_pulse();
      do_step_b(32'h0000_007F);
      chk_vb(31, "s_v0_s1");
      do_step_b(32'h0000_007F);
      chk_vb(71, "s_v0_s2");
      do_step_b(32'h0000_009C);
      chk_vb(110, "s_v0_s3");
      do_step_b(32'h0000_007F);
      chk_vb(127, "s_clamp");
      chk("s_no_spike", spk_valid_b, 0);
      do_step_b(32'h0000_007F);
      chk_vb(-20, "s_spike_reset");
      chk("s_spk_valid", spk_valid_b, 1);
      chk("s_spk_ch", spk_ch_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
